// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_pkg
// Purpose  : Shared definitions for the seven-segment scanner: digit-code
//            width, segment patterns {a,b,c,d,e,f,g} (MSB = a, active-high)
//            and the two-state scan FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package seven_segment_pkg;

    localparam int c_code_w = 3;
    localparam int c_seg_w  = 7;

    typedef logic [c_code_w-1:0] code_t;
    typedef logic [c_seg_w-1:0]  seg_t;

    // Segment patterns, order {a,b,c,d,e,f,g}
    localparam seg_t c_seg_0   = 7'b1111110;
    localparam seg_t c_seg_1   = 7'b0110000;
    localparam seg_t c_seg_2   = 7'b1101101;
    localparam seg_t c_seg_3   = 7'b1111001;
    localparam seg_t c_seg_err = 7'b1001111;   // "E"

    // Scan FSM encoding
    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_drive = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_decoder
// Purpose  : Combinational digit-code to segment-pattern decoder.
//            Codes 0..3 show the digit, every other code shows "E".
// Ports    : code - 3-bit digit code in
//            seg  - 7-bit segment pattern {a..g} out, active-high
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [c_code_w-1:0] code,
    output logic [c_seg_w-1:0]  seg
);

    always_comb begin
        seg = c_seg_err;
        case (code)
            3'd0:    seg = c_seg_0;
            3'd1:    seg = c_seg_1;
            3'd2:    seg = c_seg_2;
            3'd3:    seg = c_seg_3;
            default: seg = c_seg_err;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Purpose  : Multiplexed seven-segment display scanner with double-buffered
//            digit codes. Writes land in a shadow bank; a commit copies the
//            shadow bank to the displayed (active) bank only at a frame
//            boundary so a frame never shows a mix of old and new digits.
//            Each digit slot starts with an all-off blanking interval.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            enable           - scanning enabled when high
//            wr_en/idx/code   - shadow digit write; wr_ack / wr_err pulse
//                               one cycle later (accepted / out of range)
//            commit           - request shadow->active copy at next frame
//                               boundary; commit_done pulses when it happens
//            seg, dig_en      - registered segment and one-hot digit drives
//            frame_tick       - pulse at each scan-index wrap
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [2:0]          wr_idx,
    input  logic [2:0]          wr_code,
    output logic                wr_ack,
    output logic                wr_err,
    input  logic                commit,
    output logic                commit_done,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] dig_en,
    output logic                frame_tick
);

    localparam int c_idx_w = $clog2(N_DIGITS);
    localparam int c_cnt_w = $clog2(SLOT_CYCLES);

    localparam logic [c_cnt_w-1:0]  c_cnt_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_slot_last  = c_cnt_w'(SLOT_CYCLES - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last       = c_idx_w'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_dig_one        = {{(N_DIGITS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;       // cycle within the current slot
    logic [c_idx_w-1:0] r_idx;       // digit being scanned
    logic               r_pending;
    code_t              r_shadow [N_DIGITS];
    code_t              r_active [N_DIGITS];

    logic               r_wr_ack;
    logic               r_wr_err;
    logic               r_commit_done;
    logic               r_frame_tick;
    seg_t               r_seg;
    logic [N_DIGITS-1:0] r_dig_en;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic  w_idx_ok;
    logic  w_wr_ok;
    logic  w_boundary;
    logic  w_copy;
    code_t w_shadow_nxt [N_DIGITS];
    seg_t  w_dec_seg;

    assign w_idx_ok = ({1'b0, wr_idx} < 4'(N_DIGITS));
    assign w_wr_ok  = wr_en && w_idx_ok;

    // Frame boundary: the last drive cycle of the last digit.
    assign w_boundary = enable && (r_state == c_st_drive) &&
                        (r_cnt == c_cnt_slot_last) && (r_idx == c_idx_last);

    // While disabled the display is dark, so a commit may land immediately.
    assign w_copy = (r_pending || commit) && (w_boundary || !enable);

    // Shadow bank as it will be after this cycle's write; the copy source,
    // so a write accepted together with the copy is included in it.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_wr_ok) begin
            w_shadow_nxt[wr_idx[c_idx_w-1:0]] = wr_code;
        end
    end

    seven_segment_decoder u_decoder (
        .code (r_active[r_idx]),
        .seg  (w_dec_seg)
    );

    // ------------------------------------------------------------------
    // Scan FSM: BLANK -> DRIVE -> BLANK, slot counter runs across both
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state <= c_st_blank;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_st_blank: begin
                    if (r_cnt == c_cnt_blank_last) begin
                        r_state <= c_st_drive;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                c_st_drive: begin
                    if (r_cnt == c_cnt_slot_last) begin
                        r_state <= c_st_blank;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_blank;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow / active banks and commit tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_copy) begin
                r_active  <= w_shadow_nxt;
                r_pending <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs; seg/dig_en follow the current FSM state one
    // cycle later, and go dark on the same edge enable is seen low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ack      <= 1'b0;
            r_wr_err      <= 1'b0;
            r_commit_done <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_seg         <= '0;
            r_dig_en      <= '0;
        end else begin
            r_wr_ack      <= w_wr_ok;
            r_wr_err      <= wr_en && !w_idx_ok;
            r_commit_done <= w_copy;
            r_frame_tick  <= w_boundary;
            if (enable && (r_state == c_st_drive)) begin
                r_seg    <= w_dec_seg;
                r_dig_en <= c_dig_one << r_idx;
            end else begin
                r_seg    <= '0;
                r_dig_en <= '0;
            end
        end
    end

    assign wr_ack      = r_wr_ack;
    assign wr_err      = r_wr_err;
    assign commit_done = r_commit_done;
    assign frame_tick  = r_frame_tick;
    assign seg         = r_seg;
    assign dig_en      = r_dig_en;

endmodule
`default_nettype wire
